mmss_stopwatch: RTL

MMSS_STOPWATCH -- requirements
Module: mmss_stopwatch

---
 rtl/mmss_stopwatch_pkg.sv | 21 ++
 rtl/mmss_stopwatch_btn_debounce.sv | 45 ++++
 rtl/mmss_stopwatch.sv | 111 +++++++++++
 3 files changed

// File: rtl/mmss_stopwatch_pkg.sv
// Shared definitions for the MM:SS stopwatch: FSM state encodings, BCD digit
// type and a saturating-wrap BCD digit increment helper.
package mmss_stopwatch_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Wraps to zero after the digit's highest legal value, so a digit can never
  // leave its BCD range.
  function automatic digit_t bcd_inc(input digit_t d, input digit_t max);
    return (d == max) ? '0 : d + digit_t'(1);
  endfunction

endpackage

// File: rtl/mmss_stopwatch_btn_debounce.sv
// Raw active-low pushbutton conditioner: 2-flop synchronizer, stability
// counter and a one-cycle pulse on each accepted press (never on release).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync0;
  logic          sync1;
  logic          stable;
  logic [CW-1:0] cnt;

  // The counter runs only while the synchronized level disagrees with the
  // accepted level; any agreeing sample restarts the stability window.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0  <= 1'b1;
      sync1  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync0 <= btn_n;
      sync1 <= sync0;
      press <= 1'b0;
      if (sync1 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync1;
        cnt    <= '0;
        press  <= stable;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mmss_stopwatch.sv
// MM:SS stopwatch: two debounced buttons drive an IDLE/RUNNING/PAUSED FSM
// which gates a one-second prescaler feeding a four-digit BCD counter.
module mmss_stopwatch
  import mmss_stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = 27000000,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start_n,
  input  logic        btn_clear_n,
  output logic [15:0] number,
  output logic        colon_en,
  output logic        running
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PS_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PS_HALF = PW'(CLK_HZ / 2);

  logic          start_p;
  logic          clear_p;
  state_t        state;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_inc;
  logic          tick;
  digit_t        sec_ones;
  digit_t        sec_tens;
  digit_t        min_ones;
  digit_t        min_tens;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_start_n),
    .press (start_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_clear_n),
    .press (clear_p)
  );

  assign presc_inc = (presc == PS_MAX) ? '0 : presc + PW'(1);
  assign tick      = (state == RUNNING) && (presc == PS_MAX);
  assign number    = {min_tens, min_ones, sec_tens, sec_ones};

  // Clear overrides start and any pending tick; a tick arriving with a start
  // pulse is still counted because tick depends only on the current state.
  // colon_en is computed from the prescaler value the next cycle will hold.
  always_ff @(posedge clk) begin
    if (rst || clear_p) begin
      state    <= IDLE;
      presc    <= '0;
      sec_ones <= '0;
      sec_tens <= '0;
      min_ones <= '0;
      min_tens <= '0;
      colon_en <= 1'b0;
      running  <= 1'b0;
    end else begin
      if (tick) begin
        sec_ones <= bcd_inc(sec_ones, 4'd9);
        if (sec_ones == 4'd9) begin
          sec_tens <= bcd_inc(sec_tens, 4'd5);
          if (sec_tens == 4'd5) begin
            min_ones <= bcd_inc(min_ones, 4'd9);
            if (min_ones == 4'd9) begin
              min_tens <= bcd_inc(min_tens, 4'd5);
            end
          end
        end
      end
      case (state)
        IDLE: begin
          if (start_p) begin
            state    <= RUNNING;
            running  <= 1'b1;
            colon_en <= 1'b1;
          end
        end
        RUNNING: begin
          presc <= presc_inc;
          if (start_p) begin
            state    <= PAUSED;
            running  <= 1'b0;
            colon_en <= 1'b1;
          end else begin
            colon_en <= (presc_inc < PS_HALF);
          end
        end
        PAUSED: begin
          if (start_p) begin
            state    <= RUNNING;
            running  <= 1'b1;
            colon_en <= (presc < PS_HALF);
          end
        end
        default: begin
          state    <= IDLE;
          running  <= 1'b0;
          colon_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
